// File: rtl/wb_dma_copy_pkg.sv
// Shared definitions for the Wishbone block-copy initiator.
package wb_dma_copy_pkg;

    // Copy sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        FIN  = 2'd3
    } state_e;

    // Byte select for full 32-bit word accesses
    localparam logic [3:0] SEL_ALL = 4'hF;

    // Byte-address step between consecutive words
    localparam int unsigned ADDR_INC = 4;

endpackage

// File: rtl/wb_dma_copy_timeout.sv
// Per-access watchdog: down-counter loaded with TIMEOUT on clear, counts
// while enabled, and flags expiry once it has sat at zero for a cycle with
// the access still open. TIMEOUT=0 disables expiry entirely.
module wb_timeout #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Clear has priority over counting; counter parks at zero
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = CW'(TIMEOUT);
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    // Counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= CW'(TIMEOUT);
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (TIMEOUT != 0) && en_i && (cnt_q == '0);

endmodule

// File: rtl/wb_dma_copy.sv
// Wishbone classic initiator copying len 32-bit words from src to dst,
// one read/write pair per word, with a per-access ack timeout.
module wb_dma_copy
    import wb_dma_copy_pkg::*;
#(
    parameter int          AW      = 15,
    parameter int          LW      = 13,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_i,
    input  logic [AW-1:0] src_i,
    input  logic [AW-1:0] dst_i,
    input  logic [LW-1:0] len_i,
    output logic          busy_o,
    output logic          done_o,
    output logic          err_o,
    output logic [AW-1:0] adr_o,
    output logic [31:0]   dat_o,
    input  logic [31:0]   dat_i,
    output logic [3:0]    sel_o,
    output logic          we_o,
    output logic          cyc_o,
    output logic          stb_o,
    input  logic          ack_i
);

    localparam logic [AW-1:0] ADR_MASK = ~AW'(3);
    localparam logic [AW-1:0] ADR_INC  = AW'(ADDR_INC);

    state_e        state_q, state_d;
    logic [AW-1:0] src_q, src_d;
    logic [AW-1:0] dst_q, dst_d;
    logic [LW-1:0] len_q, len_d;
    logic [AW-1:0] adr_q, adr_d;
    logic [31:0]   dat_q, dat_d;
    logic [3:0]    sel_q, sel_d;
    logic          we_q, we_d;
    logic          cyc_q, cyc_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          tmo_clr;
    logic          tmo_exp;

    wb_timeout #(
        .TIMEOUT(TIMEOUT)
    ) u_tmo (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (tmo_clr),
        .en_i     (cyc_q),
        .expired_o(tmo_exp)
    );

    // Next-state and next-output logic; outputs are all registered so every
    // bus change lands exactly on the edge where ack is sampled
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        len_d   = len_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        we_d    = we_q;
        cyc_d   = cyc_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = err_q;
        tmo_clr = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    err_d  = 1'b0;
                    busy_d = 1'b1;
                    if (len_i == '0) begin
                        done_d  = 1'b1;
                        state_d = FIN;
                    end else begin
                        src_d   = src_i & ADR_MASK;
                        dst_d   = dst_i & ADR_MASK;
                        len_d   = len_i;
                        adr_d   = src_i & ADR_MASK;
                        we_d    = 1'b0;
                        cyc_d   = 1'b1;
                        tmo_clr = 1'b1;
                        state_d = RD;
                    end
                end
            end
            RD: begin
                if (ack_i) begin
                    dat_d   = dat_i;
                    adr_d   = dst_q;
                    we_d    = 1'b1;
                    tmo_clr = 1'b1;
                    state_d = WR;
                end else if (tmo_exp) begin
                    cyc_d   = 1'b0;
                    we_d    = 1'b0;
                    busy_d  = 1'b0;
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            WR: begin
                if (ack_i) begin
                    src_d = src_q + ADR_INC;
                    dst_d = dst_q + ADR_INC;
                    len_d = len_q - LW'(1);
                    we_d  = 1'b0;
                    if (len_q == LW'(1)) begin
                        cyc_d   = 1'b0;
                        done_d  = 1'b1;
                        state_d = FIN;
                    end else begin
                        adr_d   = src_q + ADR_INC;
                        tmo_clr = 1'b1;
                        state_d = RD;
                    end
                end else if (tmo_exp) begin
                    cyc_d   = 1'b0;
                    we_d    = 1'b0;
                    busy_d  = 1'b0;
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            FIN: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        sel_d = cyc_d ? SEL_ALL : 4'h0;
    end

    // State, address/length, capture and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            adr_q   <= '0;
            dat_q   <= '0;
            sel_q   <= '0;
            we_q    <= 1'b0;
            cyc_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            len_q   <= len_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            sel_q   <= sel_d;
            we_q    <= we_d;
            cyc_q   <= cyc_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign err_o  = err_q;
    assign adr_o  = adr_q;
    assign dat_o  = dat_q;
    assign sel_o  = sel_q;
    assign we_o   = we_q;
    assign cyc_o  = cyc_q;
    assign stb_o  = cyc_q;

endmodule
